// File: rtl/img_frame_packer_pkg.sv
// Shared definitions for the image-record packer.
//   state_e        : packer FSM state encodings
//   FletcherMod    : Fletcher-32 modulus (65535)
//   swap16         : host-order to card-order (byte swap) conversion
//   fletcher_fold  : single conditional subtract of the modulus on a 17-bit sum
//   cnt_width      : counter width able to hold 0..max_val (never below 1 bit)
package img_frame_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PIX,
        ST_CKA,
        ST_CKB,
        ST_PAD,
        ST_FIN
    } state_e;

    localparam logic [15:0] FletcherMod = 16'hFFFF;

    function automatic logic [15:0] swap16(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    // Both operands of every add are < 65536, so one subtract is always enough.
    function automatic logic [15:0] fletcher_fold(input logic [16:0] x);
        return (x >= {1'b0, FletcherMod}) ? 16'(x - {1'b0, FletcherMod}) : x[15:0];
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fletcher32_accum.sv
// Fletcher-32 running sums over 16-bit host-order words.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of both sums (has priority over en)
//   en         : fold din into the sums this cycle
//   din[15:0]  : data word, host order
//   a, b       : registered sums; valid the cycle after the last en
module fletcher32_accum
    import img_frame_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] a,
    output logic [15:0] b
);

    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        a_d = a_q;
        b_d = b_q;
        if (clr) begin
            a_d = '0;
            b_d = '0;
        end else if (en) begin
            a_d = fletcher_fold({1'b0, a_q} + {1'b0, din});
            // b folds in the already-updated a.
            b_d = fletcher_fold({1'b0, b_q} + {1'b0, a_d});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a = a_q;
    assign b = b_q;

endmodule

// File: rtl/img_frame_packer.sv
// Image-record packer: header words, filtered pixels, Fletcher-32 checksum,
// then zero padding up to a whole SD block. Every emitted word is byte-swapped.
//   clk, rst_n            : clock, async active-low reset
//   start                 : 1-cycle frame start (ignored while busy)
//   busy                  : frame in progress
//   done                  : 1-cycle pulse after the last word is accepted downstream
//   hdr_data/valid/ready  : header word input, host order
//   pix_data/valid/ready  : pixel input, host order
//   out_data/valid/ready  : record word output, card order
module img_frame_packer
    import img_frame_packer_pkg::*;
#(
    parameter int HeaderWordCount = 8,
    parameter int ImageWidth      = 2304,
    parameter int ImageHeight     = 1296,
    parameter int FilterPeriod    = 1,
    parameter int FilterKeep      = 1,
    parameter int BlockWords      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [15:0] hdr_data,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PixCnt = ImageWidth * ImageHeight;
    localparam int PadCnt = (BlockWords - (HeaderWordCount + PixCnt + 2) % BlockWords) % BlockWords;

    localparam int HdrW   = cnt_width(HeaderWordCount);
    localparam int PixW   = cnt_width(PixCnt);
    localparam int PadW   = cnt_width(PadCnt);
    localparam int PhaseW = cnt_width(FilterPeriod);

    // Terminal counts; unused (and harmlessly all-ones) when the matching count is 0.
    localparam logic [HdrW-1:0]   HdrLast   = HdrW'(HeaderWordCount - 1);
    localparam logic [PixW-1:0]   PixLast   = PixW'(PixCnt - 1);
    localparam logic [PadW-1:0]   PadLast   = PadW'(PadCnt - 1);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(FilterPeriod - 1);
    localparam logic [PhaseW-1:0] PhaseKeep = PhaseW'(FilterKeep);

    localparam state_e FirstState = (HeaderWordCount == 0) ? ST_PIX : ST_HDR;

    state_e            state_q, state_d;
    logic [HdrW-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [PadW-1:0]   pad_cnt_q, pad_cnt_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    logic        can_load;
    logic        keep;
    logic        load;
    logic [15:0] load_word;
    logic        hdr_ready_c;
    logic        pix_ready_c;
    logic        acc_clr;
    logic        acc_en;
    logic [15:0] acc_din;
    logic [15:0] acc_a;
    logic [15:0] acc_b;

    fletcher32_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (acc_din),
        .a     (acc_a),
        .b     (acc_b)
    );

    // The output register can take a new word when empty or draining this cycle.
    assign can_load = !out_valid_q || out_ready;
    assign keep     = (phase_q < PhaseKeep);

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        load        = 1'b0;
        load_word   = '0;
        hdr_ready_c = 1'b0;
        pix_ready_c = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        acc_din     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = FirstState;
                    hdr_cnt_d = '0;
                    pix_cnt_d = '0;
                    pad_cnt_d = '0;
                    phase_d   = '0;
                    acc_clr   = 1'b1;
                end
            end

            ST_HDR: begin
                hdr_ready_c = can_load;
                if (hdr_valid && can_load) begin
                    load      = 1'b1;
                    load_word = swap16(hdr_data);
                    acc_en    = 1'b1;
                    acc_din   = hdr_data;
                    if (hdr_cnt_q == HdrLast) begin
                        state_d = ST_PIX;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + HdrW'(1);
                    end
                end
            end

            ST_PIX: begin
                // Dropped pixels never touch the output register, so they need no space.
                pix_ready_c = !keep || can_load;
                if (pix_valid && pix_ready_c) begin
                    phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseW'(1);
                    if (keep) begin
                        load      = 1'b1;
                        load_word = swap16(pix_data);
                        acc_en    = 1'b1;
                        acc_din   = pix_data;
                        if (pix_cnt_q == PixLast) begin
                            state_d = ST_CKA;
                        end else begin
                            pix_cnt_d = pix_cnt_q + PixW'(1);
                        end
                    end
                end
            end

            ST_CKA: begin
                // The sums already include the last kept pixel: it was folded in on its load edge.
                if (can_load) begin
                    load      = 1'b1;
                    load_word = swap16(acc_a);
                    state_d   = ST_CKB;
                end
            end

            ST_CKB: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = swap16(acc_b);
                    state_d   = (PadCnt == 0) ? ST_FIN : ST_PAD;
                end
            end

            ST_PAD: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = '0;
                    if (pad_cnt_q == PadLast) begin
                        state_d = ST_FIN;
                    end else begin
                        pad_cnt_d = pad_cnt_q + PadW'(1);
                    end
                end
            end

            ST_FIN: begin
                // The last word is still in the output register; wait for it to drain.
                if (can_load) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            pad_cnt_q   <= '0;
            phase_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            phase_q     <= phase_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hdr_ready = hdr_ready_c;
    assign pix_ready = pix_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
